// File: rtl/nrisc_ula_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic, bit-serial shifts and rotates.
// Define NRISC_ULA_MUL_EN to add a shift-add unsigned multiplier on ctrl=1010.
module nrisc_ula_mc #(
    parameter int unsigned TAM = 16,
    parameter int unsigned SHW = $clog2(TAM)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [TAM-1:0] ULA_A,
    input  logic [TAM-1:0] ULA_B,
    input  logic [3:0]     ULA_ctrl,
    input  logic           ULA_start,
    output logic           ULA_busy,
    output logic           ULA_done,
    output logic [TAM-1:0] ULA_OUT,
    output logic [2:0]     ULA_flags
);
    localparam int unsigned CW = SHW + 1;
    localparam int unsigned TW = TAM + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [TAM-1:0] a_q, a_d;
    logic [TAM-1:0] b_q, b_d;
    logic [3:0]     ctrl_q, ctrl_d;
    logic           cin_q, cin_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TAM-1:0] out_q, out_d;
    logic [2:0]     flags_q, flags_d;
    logic           busy_q, done_q;

    logic [TW-1:0]  sum, diff;
    logic [TAM-1:0] shr, shl, res;
    logic           cout, fin;

`ifdef NRISC_ULA_MUL_EN
    logic [TAM-1:0] hi_q, hi_d;
    logic [TW-1:0]  mac;
    logic [TAM-1:0] mlo;

    // One shift-add step: high half accumulates A, low half shifts in the product LSB.
    assign mac = TW'(hi_q) + (b_q[0] ? TW'(a_q) : TW'(0));
    assign mlo = {mac[0], b_q[TAM-1:1]};
`endif

    // Carry-in and borrow-in come from the flag captured at start, only with the modifier.
    assign sum  = TW'(a_q) + TW'(b_q) + TW'(ctrl_q[3] & cin_q);
    assign diff = TW'(a_q) - TW'(b_q) - TW'(ctrl_q[3] & cin_q);
    assign shr  = {ctrl_q[3] & a_q[0], a_q[TAM-1:1]};
    assign shl  = {a_q[TAM-2:0], ctrl_q[3] & a_q[TAM-1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        flags_d = flags_q;
        res     = '0;
        cout    = 1'b0;
        fin     = 1'b0;
`ifdef NRISC_ULA_MUL_EN
        hi_d    = hi_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (ULA_start) begin
                    a_d     = ULA_A;
                    b_d     = ULA_B;
                    ctrl_d  = ULA_ctrl;
                    cin_d   = flags_q[0];
                    cnt_d   = CW'(ULA_B[SHW-1:0]);
`ifdef NRISC_ULA_MUL_EN
                    hi_d    = '0;
                    if (ULA_ctrl == 4'b1010) begin
                        cnt_d = CW'(TAM);
                    end
`endif
                    state_d = EXEC;
                end
            end
            EXEC: begin
                fin = 1'b1;
`ifdef NRISC_ULA_MUL_EN
                if (ctrl_q == 4'b1010) begin
                    hi_d  = mac[TAM:1];
                    b_d   = mlo;
                    cnt_d = cnt_q - CW'(1);
                    res   = mlo;
                    cout  = |mac[TAM:1];
                    fin   = (cnt_q == CW'(1));
                end else
`endif
                begin
                    unique case (ctrl_q[2:0])
                        3'b000: begin
                            res  = sum[TAM-1:0];
                            cout = sum[TAM];
                        end
                        3'b001: begin
                            res  = diff[TAM-1:0];
                            cout = diff[TAM];
                        end
                        3'b010: res = a_q & b_q;
                        3'b011: res = a_q | b_q;
                        3'b100: res = a_q ^ b_q;
                        3'b111: res = ~a_q;
                        3'b101, 3'b110: begin
                            // ctrl[0] distinguishes right (101) from left (110).
                            if (cnt_q != '0) begin
                                res   = ctrl_q[0] ? shr : shl;
                                cout  = ctrl_q[0] ? a_q[0] : a_q[TAM-1];
                                a_d   = res;
                                cnt_d = cnt_q - CW'(1);
                                fin   = (cnt_q == CW'(1));
                            end else begin
                                res = a_q;
                            end
                        end
                    endcase
                end
                if (fin) begin
                    out_d   = res;
                    flags_d = {res[TAM-1], res == '0, cout};
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef NRISC_ULA_MUL_EN
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            flags_q <= flags_d;
            busy_q  <= (state_d == EXEC);
            done_q  <= (state_d == DONE);
`ifdef NRISC_ULA_MUL_EN
            hi_q    <= hi_d;
`endif
        end
    end

    assign ULA_OUT   = out_q;
    assign ULA_flags = flags_q;
    assign ULA_busy  = busy_q;
    assign ULA_done  = done_q;

endmodule

// File: tb/tb_nrisc_ula_mc.sv
// Directed bench for nrisc_ula_mc at TAM=16; honours NRISC_ULA_MUL_EN for the 1010 case.
module tb_nrisc_ula_mc;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ULA_A, ULA_B;
    logic [3:0]  ULA_ctrl;
    logic        ULA_start;
    logic        ULA_busy, ULA_done;
    logic [15:0] ULA_OUT;
    logic [2:0]  ULA_flags;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    nrisc_ula_mc #(.TAM(16)) dut (
        .clk(clk), .rst(rst), .ULA_A(ULA_A), .ULA_B(ULA_B), .ULA_ctrl(ULA_ctrl),
        .ULA_start(ULA_start), .ULA_busy(ULA_busy), .ULA_done(ULA_done),
        .ULA_OUT(ULA_OUT), .ULA_flags(ULA_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge. elat counts the start edge.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] c, input logic [15:0] eo, input logic [2:0] ef,
                          input int elat);
        int edges;
        int busy_cnt;
        ULA_A = a; ULA_B = b; ULA_ctrl = c; ULA_start = 1'b1;
        @(posedge clk);
        edges = 1;
        busy_cnt = 0;
        @(negedge clk);
        ULA_start = 1'b0;
        ULA_A = ~a; ULA_B = ~b; ULA_ctrl = ~c;
        while (ULA_done !== 1'b1 && edges < 100) begin
            if (ULA_busy === 1'b1) busy_cnt++;
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'(elat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(elat - 1));
        check({tag, "_out"}, 32'(ULA_OUT), 32'(eo));
        check({tag, "_flags"}, 32'(ULA_flags), 32'(ef));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'({ULA_done, ULA_busy}), 32'(0));
        check({tag, "_hold"}, 32'(ULA_OUT), 32'(eo));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        ULA_A = '0; ULA_B = '0; ULA_ctrl = '0; ULA_start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out", 32'(ULA_OUT), 32'(0));
        check("reset_flags", 32'(ULA_flags), 32'(0));
        check("reset_busy_done", 32'({ULA_busy, ULA_done}), 32'(0));
        rst = 1'b1;

        run_op("add_ovf", 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 3'b011, 2);
        run_op("and",     16'hF0F0, 16'hFF00, 4'b0010, 16'hF000, 3'b100, 2);
        run_op("sub",     16'h0003, 16'h0005, 4'b0001, 16'hFFFE, 3'b101, 2);
        run_op("adc",     16'h0001, 16'h0001, 4'b1000, 16'h0003, 3'b000, 2);
        run_op("lsr4",    16'h8001, 16'h0004, 4'b0101, 16'h0800, 3'b000, 5);
        run_op("ror1",    16'h0001, 16'h0001, 4'b1101, 16'h8000, 3'b101, 2);
        run_op("lsl2",    16'hC000, 16'h0002, 4'b0110, 16'h0000, 3'b011, 3);
        run_op("rol0",    16'h1234, 16'h0010, 4'b1110, 16'h1234, 3'b000, 2);
        run_op("or_zero", 16'h0000, 16'h0000, 4'b0011, 16'h0000, 3'b010, 2);
        run_op("xor_mod", 16'h1234, 16'h1234, 4'b1100, 16'h0000, 3'b010, 2);
        run_op("not",     16'hFFFF, 16'h0000, 4'b0111, 16'h0000, 3'b010, 2);
`ifdef NRISC_ULA_MUL_EN
        run_op("mul",     16'h0100, 16'h0100, 4'b1010, 16'h0000, 3'b011, 17);
`else
        run_op("mul_as_and", 16'h0100, 16'h0100, 4'b1010, 16'h0100, 3'b000, 2);
`endif
        run_op("xor",     16'hAAAA, 16'h5555, 4'b0100, 16'hFFFF, 3'b100, 2);

        // Abort a 15-step shift during its third EXEC cycle.
        ULA_A = 16'h1234; ULA_B = 16'h000F; ULA_ctrl = 4'b0101; ULA_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ULA_start = 1'b0;
        check("abort_busy_exec1", 32'(ULA_busy), 32'(1));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(ULA_busy), 32'(0));
        check("abort_out", 32'(ULA_OUT), 32'(0));
        check("abort_flags", 32'(ULA_flags), 32'(0));
        check("abort_done", 32'(ULA_done), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'({ULA_done, ULA_busy}), 32'(0));
        end
        rst = 1'b1;
        run_op("post_reset_add", 16'h0002, 16'h0003, 4'b1000, 16'h0005, 3'b000, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/nrisc_ula_mc.md
NRISC_ULA_MC -- requirements
Module: nrisc_ula_mc

Interface
REQ-001 SHALL have parameter TAM, default 16, meaning operand/result width; legal values are powers of two, 4 to 64.
REQ-002 SHALL have parameter SHW, default $clog2(TAM), meaning shift-amount width.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port ULA_A, input, TAM bits: operand A.
REQ-006 SHALL have port ULA_B, input, TAM bits: operand B; B[SHW-1:0] is the shift/rotate amount n.
REQ-007 SHALL have port ULA_ctrl, input, 4 bits: bits [2:0] select the function; bit 3 is the modifier.
REQ-008 SHALL have port ULA_start, input, 1 bit: request; sampled only while idle.
REQ-009 SHALL have port ULA_busy, output, 1 bit: operation in progress.
REQ-010 SHALL have port ULA_done, output, 1 bit: one-cycle pulse marking a new valid result.
REQ-011 SHALL have port ULA_OUT, output, TAM bits: registered result.
REQ-012 SHALL have port ULA_flags, output, 3 bits: registered {minus, zero, carry}.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, DONE; reset state is IDLE.
REQ-014 SHALL, when ULA_start=1 in IDLE, capture A, B, ctrl and the current carry flag, then enter EXEC; operand changes after capture have no effect.
REQ-015 SHALL ignore ULA_start in EXEC and DONE; no queuing.
REQ-016 SHALL drive ULA_busy=1 exactly while in EXEC.
REQ-017 SHALL, in DONE, drive ULA_done=1 for one cycle, then return to IDLE.
REQ-018 SHALL update ULA_OUT and ULA_flags on the same edge that enters DONE, and hold them until the next DONE.
REQ-019 SHALL decode ctrl[2:0] as: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 right shift, 110 left shift, 111 not A.
REQ-020 SHALL, for add with ctrl[3]=1, perform add-with-carry using the captured carry flag as carry-in.
REQ-021 SHALL, for sub with ctrl[3]=1, perform subtract-with-borrow using the captured carry flag as borrow-in.
REQ-022 SHALL, for add/sub, set carry to the unsigned carry-out (add) or the unsigned borrow (sub).
REQ-023 SHALL, for shifts, treat ctrl[3]=0 as logical shift with zero fill and ctrl[3]=1 as rotate.
REQ-024 SHALL, for shifts, perform one bit per EXEC cycle, n cycles in total.
REQ-025 SHALL, for shifts, set carry to the last bit shifted or rotated out; carry=0 when n=0.
REQ-026 SHALL, for and/or/xor/not, set carry=0; ctrl[3] is ignored for these functions (except REQ-036).
REQ-027 SHALL give latency from the start edge to the DONE-entry edge of 1 cycle for non-shift operations.
REQ-028 SHALL give shift latency of max(n,1)+1 edges.
REQ-029 SHALL set minus = ULA_OUT[TAM-1].
REQ-030 SHALL set zero = (ULA_OUT == 0).
REQ-031 SHALL discard all carries beyond TAM bits; results wrap modulo 2^TAM.

Reset
REQ-032 SHALL, on rst=0 at any time including mid-EXEC, immediately force state IDLE and clear ULA_OUT, ULA_flags, ULA_busy, ULA_done and all internal registers to 0.
REQ-033 SHALL produce no ULA_done for an operation aborted by reset.
REQ-034 SHALL accept ULA_start on the first rising edge after rst deasserts.

Configuration
REQ-035 SHALL be controlled by macro NRISC_ULA_MUL_EN.
REQ-036 SHALL, with NRISC_ULA_MUL_EN defined, execute ctrl=1010 as an unsigned multiply: low TAM bits to ULA_OUT; carry=1 if the high half is nonzero; shift-add, TAM EXEC cycles, latency TAM+1 edges.
REQ-037 SHALL, without NRISC_ULA_MUL_EN, execute ctrl=1010 as and, with no multiplier logic synthesised.

Verification (TAM=16)
REQ-038 SHALL cover add overflow: A=FFFF, B=0001, ctrl=0000 -> OUT=0000, flags=011, ULA_done on the 2nd edge after start.
REQ-039 SHALL cover subtract-then-add-with-carry: A=0003, B=0005, ctrl=0001 -> OUT=FFFE, flags=101; then A=0001, B=0001, ctrl=1000 -> OUT=0003, flags=000.
REQ-040 SHALL cover logical right shift: A=8001, B=0004, ctrl=0101 -> OUT=0800, flags=000, latency 5 edges, ULA_busy high for 4 cycles.
REQ-041 SHALL cover rotate right: A=0001, B=0001, ctrl=1101 -> OUT=8000, flags=101.
REQ-042 SHALL cover multiply (macro defined): A=0100, B=0100, ctrl=1010 -> OUT=0000, flags=011, latency 17 edges; without the macro -> OUT=0100, flags=000.
REQ-043 SHALL cover reset mid-shift: B=000F shift, rst=0 at the 3rd EXEC cycle -> busy=0, OUT=0000, flags=000 immediately, no ULA_done, and a new start is accepted after release.
